soc2_ram_tester: RTL and testbench

Avalon-MM master that fills a word range of the SoC2 on-chip RAM with a deterministic pattern, then reads it back pipelined and compares it against the pattern. It drives the RAM's slave port, either directly or through the interconnect, and serves as a built-in memory self-test and bring-up engine. Software or a top-level FSM starts it and reads back the pass/fail results.

---
 rtl/soc2_ram_tester.sv | 173 +++++++++++++++++
 tb/tb_soc2_ram_tester.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc2_ram_tester.sv
// soc2_ram_tester: Avalon-MM RAM self-test master.
// Writes a seeded pattern over a word range, reads it back pipelined, counts mismatches.
module soc2_ram_tester #(
    parameter int ADDR_W       = 13,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [31:0]       seed,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W:0]         len_q;
    logic [ADDR_W:0]         idx;
    logic [31:0]             seed_q;
    logic                    mode_q;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [ADDR_W-1:0]       pipe_a [READ_LATENCY];

    logic [ADDR_W-1:0] addr_cur;
    logic              accept;
    logic              last;
    logic              drain_ok;
    logic              mismatch;

    // Replicate the address upward from bit 0 to fill the 32-bit word.
    function automatic logic [31:0] pattern(
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       s,
        input logic              m
    );
        logic [31:0] rep;
        for (int j = 0; j < 32; j++) begin
            rep[j] = a[j % ADDR_W];
        end
        return m ? ~(s ^ rep) : (s ^ 32'(a));
    endfunction

    assign addr_cur = base_q + idx[ADDR_W-1:0];
    assign last     = (idx + (ADDR_W+1)'(1)) == len_q;
    assign busy     = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done     = (state == FIN);
    assign error    = |err_count;

    always_comb begin
        avm_chipselect = (state == WRITE) || (state == READ);
        avm_write      = (state == WRITE);
        avm_read       = (state == READ);
        avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
        avm_address    = avm_chipselect ? addr_cur : '0;
        avm_writedata  = '0;
        if (avm_write) begin
            avm_writedata = pattern(addr_cur, seed_q, mode_q);
        end
        accept = avm_chipselect && !avm_waitrequest;
    end

    // Only tags behind the output stage keep the pipe busy.
    always_comb begin
        drain_ok = 1'b1;
        for (int k = 0; k < READ_LATENCY - 1; k++) begin
            if (pipe_v[k]) drain_ok = 1'b0;
        end
        mismatch = pipe_v[READ_LATENCY-1] &&
            (avm_readdata != pattern(pipe_a[READ_LATENCY-1], seed_q, mode_q));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (length == '0) ? FIN : WRITE;
            end
            WRITE: begin
                if (accept && last) state_nx = READ;
            end
            READ: begin
                if (accept && last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) state_nx = FIN;
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            seed_q <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= length;
                seed_q <= seed;
                mode_q <= mode;
                idx    <= '0;
            end else if (accept) begin
                idx <= (state == WRITE && last) ? '0 : idx + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_a[k] <= '0;
            end
        end else begin
            pipe_v[0] <= (state == READ) && accept;
            pipe_a[0] <= addr_cur;
            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_a[k] <= pipe_a[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (state == IDLE && start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (err_count == '0) begin
                first_err_addr <= pipe_a[READ_LATENCY-1];
                first_err_data <= avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_soc2_ram_tester.sv
// tb_soc2_ram_tester: directed bench for soc2_ram_tester.
// Two instances (read latency 1 and 3), each on its own behavioural RAM model.
module tb_soc2_ram_tester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic [12:0] base_addr = '0;
    logic [13:0] length = '0;
    logic [31:0] seed = '0;
    logic        mode = 1'b0;

    logic        busy1, done1, error1, cs1, wr1, rd1;
    logic [15:0] errc1;
    logic [12:0] fea1, addr1;
    logic [31:0] fed1, wd1;
    logic [3:0]  be1;
    logic [31:0] rdata1 = '0;
    logic        wreq1 = 1'b0;

    logic        busy3, done3, error3, cs3, wr3, rd3;
    logic [15:0] errc3;
    logic [12:0] fea3, addr3;
    logic [31:0] fed3, wd3;
    logic [3:0]  be3;
    logic [31:0] rdata3;
    logic        wreq3 = 1'b0;
    logic [31:0] rp3 [3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [12:0] mon_base = '0;
    logic [31:0] mon_seed = '0;
    logic        mon_mode = 1'b0;
    logic        clr = 1'b0;
    logic        fault = 1'b0;
    logic        rand_en = 1'b0;

    int wc1, rc1, ad_err1, wd_err1, be_err1;
    int wc3, rc3, ad_err3, wd_err3, stab_err3, stall3;
    logic        held3;
    logic [60:0] held_v3;
    logic [31:0] mem1 [8192];
    logic [31:0] mem3 [8192];

    int fc_busy, fc_cs, fc_done;
    logic [31:0] fc_wd;

    soc2_ram_tester #(.ADDR_W(13), .READ_LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .base_addr(base_addr), .length(length), .seed(seed), .mode(mode),
        .busy(busy1), .done(done1), .error(error1), .err_count(errc1),
        .first_err_addr(fea1), .first_err_data(fed1),
        .avm_address(addr1), .avm_chipselect(cs1), .avm_write(wr1),
        .avm_read(rd1), .avm_byteenable(be1), .avm_writedata(wd1),
        .avm_readdata(rdata1), .avm_waitrequest(wreq1)
    );

    soc2_ram_tester #(.ADDR_W(13), .READ_LATENCY(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3),
        .base_addr(base_addr), .length(length), .seed(seed), .mode(mode),
        .busy(busy3), .done(done3), .error(error3), .err_count(errc3),
        .first_err_addr(fea3), .first_err_data(fed3),
        .avm_address(addr3), .avm_chipselect(cs3), .avm_write(wr3),
        .avm_read(rd3), .avm_byteenable(be3), .avm_writedata(wd3),
        .avm_readdata(rdata3), .avm_waitrequest(wreq3)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [12:0] a);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = a[j % 13];
        return mon_mode ? ~(mon_seed ^ r) : (mon_seed ^ {19'd0, a});
    endfunction

    // RAM model, latency 1, optional bit-3 corruption on two addresses.
    always @(posedge clk) begin
        if (clr) begin
            wc1 <= 0; rc1 <= 0; ad_err1 <= 0; wd_err1 <= 0; be_err1 <= 0;
        end else begin
            if (cs1 ? (be1 !== 4'hF) : (be1 !== 4'h0)) be_err1 <= be_err1 + 1;
            if (wr1 && !wreq1) begin
                mem1[addr1] <= wd1;
                wc1 <= wc1 + 1;
                if (addr1 !== 13'(mon_base + wc1[12:0])) ad_err1 <= ad_err1 + 1;
                if (wd1 !== pat(addr1)) wd_err1 <= wd_err1 + 1;
            end
            if (rd1 && !wreq1) begin
                rc1 <= rc1 + 1;
                if (addr1 !== 13'(mon_base + rc1[12:0])) ad_err1 <= ad_err1 + 1;
            end
        end
        if (rd1 && !wreq1)
            rdata1 <= mem1[addr1] ^
                ((fault && (addr1 == 13'h105 || addr1 == 13'h109)) ? 32'h8 : 32'h0);
        else
            rdata1 <= 32'hDEADBEEF;
    end

    // RAM model, latency 3, random waitrequest, stability monitor.
    always @(posedge clk) begin
        wreq3 <= rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
        if (clr) begin
            wc3 <= 0; rc3 <= 0; ad_err3 <= 0; wd_err3 <= 0;
            stab_err3 <= 0; stall3 <= 0;
        end else begin
            if (held3 && ({addr3, wd3, wr3, rd3, cs3} !== {held_v3[60:45],
                held_v3[44:0]}))
                stab_err3 <= stab_err3 + 1;
            if ((wr3 || rd3) && wreq3) stall3 <= stall3 + 1;
            if (wr3 && !wreq3) begin
                mem3[addr3] <= wd3;
                wc3 <= wc3 + 1;
                if (addr3 !== 13'(mon_base + wc3[12:0])) ad_err3 <= ad_err3 + 1;
                if (wd3 !== pat(addr3)) wd_err3 <= wd_err3 + 1;
            end
            if (rd3 && !wreq3) begin
                rc3 <= rc3 + 1;
                if (addr3 !== 13'(mon_base + rc3[12:0])) ad_err3 <= ad_err3 + 1;
            end
        end
        held3   <= (wr3 || rd3) && wreq3;
        held_v3 <= {addr3, wd3, wr3, rd3, cs3};
        rp3[0]  <= (rd3 && !wreq3) ? mem3[addr3] : 32'hDEADBEEF;
        rp3[1]  <= rp3[0];
        rp3[2]  <= rp3[1];
    end

    assign rdata3 = rp3[2];

    task automatic run1(input logic [12:0] b, input logic [13:0] n,
                        input logic [31:0] s, input logic m,
                        input int abort_at, input bit poke, output int dcyc);
        @(negedge clk);
        mon_base = b; mon_seed = s; mon_mode = m;
        base_addr = b; length = n; seed = s; mode = m;
        start1 = 1'b1; clr = 1'b1;
        dcyc = -1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            clr = 1'b0;
            start1 = poke && busy1 && (k % 3 == 0);
            base_addr = poke ? 13'h0500 : b;
            if (k == 1) begin
                fc_busy = int'(busy1); fc_cs = int'(cs1);
                fc_done = int'(done1); fc_wd = wd1;
            end
            if (k == abort_at) begin
                dcyc = -2;
                break;
            end
            if (done1) begin
                dcyc = k;
                break;
            end
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy1); end
        tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done1); end
        tests++; if (error1 !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error1); end
        tests++; if (errc1 !== 16'h0) begin fails++; $display("FAIL reset_errcnt got %h want 0", errc1); end
        tests++; if ({fea1, fed1} !== 45'h0) begin fails++; $display("FAIL reset_first got %h/%h want 0", fea1, fed1); end
        tests++; if ({cs1, wr1, rd1, be1} !== 7'h0) begin fails++; $display("FAIL reset_bus_ctl got %b want 0", {cs1, wr1, rd1, be1}); end
        tests++; if ({addr1, wd1} !== 45'h0) begin fails++; $display("FAIL reset_bus_data got %h/%h want 0", addr1, wd1); end
        reset_n = 1'b1;
    endtask

    task automatic test_clean;
        int d;
        run1(13'h0100, 14'd16, 32'hA5A5_0000, 1'b0, 0, 1'b0, d);
        tests++; if (d !== 34) begin fails++; $display("FAIL clean_done_cycle got %0d want 34", d); end
        tests++; if (fc_busy !== 1 || fc_wd !== 32'hA5A5_0100) begin fails++; $display("FAIL clean_cycle1 got busy=%0d wd=%h want 1/a5a50100", fc_busy, fc_wd); end
        tests++; if (wc1 !== 16 || rc1 !== 16) begin fails++; $display("FAIL clean_counts got %0d/%0d want 16/16", wc1, rc1); end
        tests++; if (ad_err1 + wd_err1 + be_err1 !== 0) begin fails++; $display("FAIL clean_bus got %0d/%0d/%0d want 0", ad_err1, wd_err1, be_err1); end
        tests++; if (errc1 !== 16'h0 || error1 !== 1'b0) begin fails++; $display("FAIL clean_result got %0d/%b want 0/0", errc1, error1); end
        @(negedge clk);
        tests++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL clean_done_pulse got done=%b busy=%b want 0/0", done1, busy1); end
    endtask

    task automatic test_wrap;
        int d;
        run1(13'h1FFE, 14'd4, 32'h1357_9BDF, 1'b0, 0, 1'b0, d);
        tests++; if (d !== 10) begin fails++; $display("FAIL wrap_done_cycle got %0d want 10", d); end
        tests++; if (wc1 !== 4 || rc1 !== 4 || ad_err1 !== 0 || wd_err1 !== 0) begin fails++; $display("FAIL wrap_bus got w%0d r%0d ad%0d wd%0d want 4/4/0/0", wc1, rc1, ad_err1, wd_err1); end
        tests++; if (errc1 !== 16'h0) begin fails++; $display("FAIL wrap_result got %0d want 0", errc1); end
    endtask

    task automatic test_fault;
        int d;
        fault = 1'b1;
        run1(13'h0100, 14'd16, 32'hA5A5_0000, 1'b0, 0, 1'b0, d);
        fault = 1'b0;
        tests++; if (d !== 34) begin fails++; $display("FAIL fault_done_cycle got %0d want 34", d); end
        tests++; if (errc1 !== 16'd2 || error1 !== 1'b1) begin fails++; $display("FAIL fault_count got %0d/%b want 2/1", errc1, error1); end
        tests++; if (fea1 !== 13'h0105) begin fails++; $display("FAIL fault_first_addr got %h want 0105", fea1); end
        tests++; if (fed1 !== 32'hA5A5_010D) begin fails++; $display("FAIL fault_first_data got %h want a5a5010d", fed1); end
    endtask

    task automatic test_mode1;
        int d;
        run1(13'h0ABC, 14'd8, 32'h0F0F_1234, 1'b1, 0, 1'b0, d);
        tests++; if (d !== 18) begin fails++; $display("FAIL mode1_done_cycle got %0d want 18", d); end
        tests++; if (fc_wd !== 32'h01A7_6777) begin fails++; $display("FAIL mode1_first_wd got %h want 01a76777", fc_wd); end
        tests++; if (wd_err1 !== 0 || errc1 !== 16'h0) begin fails++; $display("FAIL mode1_result got wd%0d err%0d want 0/0", wd_err1, errc1); end
    endtask

    task automatic test_random_stall;
        int d;
        @(negedge clk);
        mon_base = 13'h0200; mon_seed = 32'h1234_5678; mon_mode = 1'b1;
        base_addr = 13'h0200; length = 14'd64; seed = 32'h1234_5678; mode = 1'b1;
        start3 = 1'b1; clr = 1'b1; rand_en = 1'b1;
        d = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            start3 = 1'b0; clr = 1'b0;
            if (done3) begin
                d = k;
                break;
            end
        end
        rand_en = 1'b0;
        tests++; if (d !== 2 * 64 + 4 + stall3) begin fails++; $display("FAIL stall_done_cycle got %0d want %0d", d, 2 * 64 + 4 + stall3); end
        tests++; if (wc3 !== 64 || rc3 !== 64) begin fails++; $display("FAIL stall_counts got %0d/%0d want 64/64", wc3, rc3); end
        tests++; if (stab_err3 !== 0) begin fails++; $display("FAIL stall_stable got %0d want 0", stab_err3); end
        tests++; if (ad_err3 !== 0 || wd_err3 !== 0) begin fails++; $display("FAIL stall_bus got %0d/%0d want 0/0", ad_err3, wd_err3); end
        tests++; if (errc3 !== 16'h0 || error3 !== 1'b0) begin fails++; $display("FAIL stall_result got %0d/%b want 0/0", errc3, error3); end
    endtask

    task automatic test_len0_and_ignore;
        int d;
        run1(13'h0040, 14'd0, 32'h0, 1'b0, 0, 1'b0, d);
        tests++; if (d !== 1 || fc_busy !== 0 || fc_cs !== 0) begin fails++; $display("FAIL len0 got done@%0d busy=%0d cs=%0d want 1/0/0", d, fc_busy, fc_cs); end
        tests++; if (wc1 !== 0 || rc1 !== 0) begin fails++; $display("FAIL len0_bus got %0d/%0d want 0/0", wc1, rc1); end
        run1(13'h0300, 14'd8, 32'hCAFE_0000, 1'b0, 0, 1'b1, d);
        tests++; if (d !== 18) begin fails++; $display("FAIL ignore_done_cycle got %0d want 18", d); end
        tests++; if (wc1 !== 8 || rc1 !== 8 || ad_err1 !== 0) begin fails++; $display("FAIL ignore_bus got w%0d r%0d ad%0d want 8/8/0", wc1, rc1, ad_err1); end
        @(negedge clk);
        tests++; if (busy1 !== 1'b0 || cs1 !== 1'b0) begin fails++; $display("FAIL ignore_restart got busy=%b cs=%b want 0/0", busy1, cs1); end
    endtask

    task automatic test_reset_mid;
        int d;
        run1(13'h0100, 14'd16, 32'hA5A5_0000, 1'b0, 20, 1'b0, d);
        wreq1 = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (rd1 !== 1'b1 || addr1 !== 13'h0103) begin fails++; $display("FAIL mid_stall got rd=%b addr=%h want 1/0103", rd1, addr1); end
        reset_n = 1'b0;
        #1;
        tests++; if ({busy1, done1, error1, cs1, wr1, rd1, be1} !== 10'h0) begin fails++; $display("FAIL mid_reset_ctl got %b want 0", {busy1, done1, error1, cs1, wr1, rd1, be1}); end
        tests++; if ({addr1, wd1, errc1} !== 61'h0) begin fails++; $display("FAIL mid_reset_data got %h/%h/%h want 0", addr1, wd1, errc1); end
        @(negedge clk);
        reset_n = 1'b1;
        wreq1 = 1'b0;
        run1(13'h0100, 14'd16, 32'hA5A5_0000, 1'b0, 0, 1'b0, d);
        tests++; if (d !== 34 || errc1 !== 16'h0 || wc1 !== 16) begin fails++; $display("FAIL mid_rerun got done@%0d err=%0d w=%0d want 34/0/16", d, errc1, wc1); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_wrap;
        test_fault;
        test_mode1;
        test_random_stall;
        test_len0_and_ignore;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
